inert_seq: RTL and testbench
============================

Name: inert_seq

Overview:
- Command sequencer directly upstream of the SPI master. It drives that master's wrt/wt_data and consumes its done/rd_data.
- After reset it waits for the IMU to power up, then issues four configuration writes.
- After that, on each IMU data-ready interrupt it reads pitch-rate and Z-acceleration (low and high bytes each) and presents them as 16-bit words with a one-cycle valid strobe.
- Its outputs feed the balance-control datapath.

Parameters:
- INIT_WAIT, 16'hFFFF, clk cycles to wait after reset before the first SPI write. Benches override it to a small value.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- INT  in  1  IMU data-ready, asynchronous; double-flopped inside the block
- done  in  1  from SPI master. Level signal: goes high when a transaction ends, clears the cycle after the next wrt.
- rd_data  in  16  from SPI master; read byte is in [7:0]
- wrt  out  1  one-cycle pulse that starts an SPI transaction
- wt_data  out  16  SPI command word; must be valid in the cycle wrt is high
- ptch_rt  out  16  signed pitch rate {high byte, low byte}
- AZ  out  16  signed Z acceleration {high byte, low byte}
- vld  out  1  one-cycle pulse; ptch_rt and AZ updated together
- init_done  out  1  high once all configuration writes are complete

Behaviour:
Reset (rst high at a clk edge):
- State goes to RST_WAIT and the wait counter clears.
- wrt=0, wt_data=16'h0000, ptch_rt=0, AZ=0, vld=0, init_done=0, and both INT sync flops are 0.
- Reset mid-transaction abandons the sequence. The block restarts from RST_WAIT and never issues wrt until the wait expires again.

Done detection:
- done_rise = done & ~done_q, where done_q is registered.
- Only done_rise advances the state machine; a stale high level on done is ignored.
- This is why done being held high from the previous transaction does not re-trigger the sequencer.

INT detection:
- INT passes through two flops to give INT_s; a third flop stores the previous value.
- An INT rising edge is recorded in a sticky int_pend flag.
- int_pend clears when a read burst starts. An edge arriving during a burst sets int_pend again, so exactly one more burst follows.

State machine (wrt is asserted for exactly one cycle on entry to each CMD state):
- RST_WAIT: count up each cycle. When count==INIT_WAIT-1, go to CFG with cfg_idx=0.
- CFG: pulse wrt with wt_data=cfg_rom[cfg_idx], then go to CFG_WT.
- cfg_rom values:
  - 0: 16'h0D02 (INT on data-ready)
  - 1: 16'h1053 (accel 208 Hz)
  - 2: 16'h1150 (gyro 208 Hz)
  - 3: 16'h1460 (rounding)
- CFG_WT: on done_rise, if cfg_idx==3 go to IDLE and set init_done. Otherwise increment cfg_idx and go to CFG.
- IDLE: if int_pend, clear it, set rd_idx=0 and go to RD.
- RD: pulse wrt with wt_data=rd_rom[rd_idx], then go to RD_WT.
- rd_rom values:
  - 0: 16'hA200 (pitchL)
  - 1: 16'hA300 (pitchH)
  - 2: 16'hAC00 (AZL)
  - 3: 16'hAD00 (AZH)
- RD_WT: on done_rise, capture rd_data[7:0] into holding byte rd_idx.
  - If rd_idx==3, go to IDLE.
  - Otherwise increment rd_idx and go to RD.

Result update:
- In the cycle after the 4th capture, load ptch_rt={b1,b0} and AZ={b3,b2} simultaneously and pulse vld for 1 cycle.
- ptch_rt and AZ hold their values between bursts.

Other rules:
- wt_data holds its last value between commands.
- wrt is never high in two consecutive cycles.
- Never more than one outstanding transaction.
- INT edges before init_done are ignored: int_pend is forced to 0 until init_done.
- Latency from INT_s rise to wrt of the first read is 2 clks: the int_pend set cycle plus the IDLE decision.

Test Plan:
- Reset behaviour: INIT_WAIT=8, rst held 3 cycles then released. Outputs stay at reset values through RST_WAIT. First wrt occurs exactly 8 clks after rst falls, with wt_data=16'h0D02.
- Configuration sequence: SPI-master model returns done 40 clks after each wrt. Expect four wrt pulses carrying 0D02, 1053, 1150, 1460 in order. init_done rises on the 4th done_rise; no 5th wrt occurs.
- Read burst: model returns 34, 12, 78, 56 for the four reads, then raise INT. Expect wrt commands A200, A300, AC00, AD00. Expect vld for 1 cycle with ptch_rt=16'h1234, AZ=16'h5678.
- Stale done level: done held high continuously from the previous transaction when a new wrt issues. The block waits for the new done rise and does not advance early.
- Back-to-back INT: a second INT edge arrives during RD_WT of rd_idx=1. Exactly one additional burst follows (8 wrt total, 2 vld). An INT before init_done produces no reads.
- Reset mid-burst: assert rst during RD_WT with rd_idx=2. Outputs return to 0, and sequencing restarts from RST_WAIT with the configuration writes.

Source files
------------

// File: rtl/inert_seq.sv
// Sequencer between the balance controller and the SPI master: configures the IMU after a
// power-up wait, then on each data-ready interrupt reads pitch rate and Z acceleration.
module inert_seq #(
   parameter int unsigned INIT_WAIT = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] wt_data,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ,
   output logic        vld,
   output logic        init_done
);

   localparam logic [15:0] WaitLast = 16'(INIT_WAIT - 1);

   typedef enum logic [2:0] {
      StRstWait, StCfg, StCfgWt, StIdle, StRd, StRdWt
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  cfg_idx_q, cfg_idx_d;
   logic [1:0]  rd_idx_q, rd_idx_d;
   logic [7:0]  rbyte_q [4];
   logic [7:0]  rbyte_d [4];
   logic        wrt_q, wrt_d;
   logic [15:0] wt_data_q, wt_data_d;
   logic        upd_q, upd_d;
   logic        init_done_q, init_done_d;
   logic        int_pend_q, int_pend_d;
   logic        int_ff1_q, int_s_q, int_prev_q;
   logic        done_q;
   logic        burst_start;
   logic        done_rise, int_rise;
   logic [15:0] ptch_rt_q, az_q;
   logic        vld_q;

   function automatic logic [15:0] cfg_word(input logic [1:0] idx);
      unique case (idx)
         2'd0: return 16'h0D02;
         2'd1: return 16'h1053;
         2'd2: return 16'h1150;
         2'd3: return 16'h1460;
      endcase
   endfunction

   function automatic logic [15:0] rd_word(input logic [1:0] idx);
      unique case (idx)
         2'd0: return 16'hA200;
         2'd1: return 16'hA300;
         2'd2: return 16'hAC00;
         2'd3: return 16'hAD00;
      endcase
   endfunction

   // A level left high by the previous transaction must not advance the sequence.
   assign done_rise = done & ~done_q;
   assign int_rise  = int_s_q & ~int_prev_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cfg_idx_d   = cfg_idx_q;
      rd_idx_d    = rd_idx_q;
      rbyte_d     = rbyte_q;
      wrt_d       = 1'b0;
      wt_data_d   = wt_data_q;
      upd_d       = 1'b0;
      init_done_d = init_done_q;
      burst_start = 1'b0;
      unique case (state_q)
         StRstWait: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == WaitLast) begin
               state_d   = StCfg;
               cfg_idx_d = 2'd0;
               wrt_d     = 1'b1;
               wt_data_d = cfg_word(2'd0);
            end
         end
         StCfg: state_d = StCfgWt;
         StCfgWt: begin
            if (done_rise) begin
               if (cfg_idx_q == 2'd3) begin
                  state_d     = StIdle;
                  init_done_d = 1'b1;
               end else begin
                  state_d   = StCfg;
                  cfg_idx_d = cfg_idx_q + 2'd1;
                  wrt_d     = 1'b1;
                  wt_data_d = cfg_word(cfg_idx_q + 2'd1);
               end
            end
         end
         StIdle: begin
            if (int_pend_q) begin
               burst_start = 1'b1;
               state_d     = StRd;
               rd_idx_d    = 2'd0;
               wrt_d       = 1'b1;
               wt_data_d   = rd_word(2'd0);
            end
         end
         StRd: state_d = StRdWt;
         StRdWt: begin
            if (done_rise) begin
               rbyte_d[rd_idx_q] = rd_data[7:0];
               if (rd_idx_q == 2'd3) begin
                  state_d = StIdle;
                  upd_d   = 1'b1;
               end else begin
                  state_d   = StRd;
                  rd_idx_d  = rd_idx_q + 2'd1;
                  wrt_d     = 1'b1;
                  wt_data_d = rd_word(rd_idx_q + 2'd1);
               end
            end
         end
         default: state_d = StRstWait;
      endcase
   end

   // A new edge wins over the burst-start clear so it is never lost.
   always_comb begin
      int_pend_d = int_pend_q;
      if (!init_done_q)     int_pend_d = 1'b0;
      else if (int_rise)    int_pend_d = 1'b1;
      else if (burst_start) int_pend_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRstWait;
         cnt_q       <= '0;
         cfg_idx_q   <= '0;
         rd_idx_q    <= '0;
         for (int i = 0; i < 4; i++) rbyte_q[i] <= '0;
         wrt_q       <= 1'b0;
         wt_data_q   <= '0;
         upd_q       <= 1'b0;
         init_done_q <= 1'b0;
         int_pend_q  <= 1'b0;
         int_ff1_q   <= 1'b0;
         int_s_q     <= 1'b0;
         int_prev_q  <= 1'b0;
         done_q      <= 1'b0;
         ptch_rt_q   <= '0;
         az_q        <= '0;
         vld_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cfg_idx_q   <= cfg_idx_d;
         rd_idx_q    <= rd_idx_d;
         rbyte_q     <= rbyte_d;
         wrt_q       <= wrt_d;
         wt_data_q   <= wt_data_d;
         upd_q       <= upd_d;
         init_done_q <= init_done_d;
         int_pend_q  <= int_pend_d;
         int_ff1_q   <= INT;
         int_s_q     <= int_ff1_q;
         int_prev_q  <= int_s_q;
         done_q      <= done;
         vld_q       <= upd_q;
         if (upd_q) begin
            ptch_rt_q <= {rbyte_q[1], rbyte_q[0]};
            az_q      <= {rbyte_q[3], rbyte_q[2]};
         end
      end
   end

   assign wrt       = wrt_q;
   assign wt_data   = wt_data_q;
   assign ptch_rt   = ptch_rt_q;
   assign AZ        = az_q;
   assign vld       = vld_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_inert_seq.sv
// Self-checking bench for inert_seq: an SPI-master/IMU register model answers commands, and
// expected results are built from the model's register contents.
module tb_inert_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        INT = 1'b0;
   logic        done = 1'b0;
   logic [15:0] rd_data = 16'h0000;
   logic        wrt;
   logic [15:0] wt_data, ptch_rt, AZ;
   logic        vld, init_done;

   inert_seq #(.INIT_WAIT(8)) dut (
      .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data), .wrt(wrt),
      .wt_data(wt_data), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld), .init_done(init_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // IMU register file and SPI master model state
   logic [7:0]  mem [0:127];
   logic [15:0] wq [$];
   int          wcyc [$];
   int          dcyc [$];
   logic [31:0] vq [$];
   int          vcyc [$];
   int cyc = 0, lat = 40, stale = 0, clr_at = -1, done_at = -1, init_cyc = -1;
   int n_b2b = 0, n_ovl = 0, n_vld_b2b = 0;
   logic pend = 1'b0, wrt_last = 1'b0, vld_last = 1'b0, init_last = 1'b0;
   logic [15:0] cur = 16'h0000;
   logic [15:0] rd_cmds [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
   logic [15:0] cfg_cmds [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            pend = 1'b0; clr_at = -1; done_at = -1;
         end else begin
            if (wrt) begin
               if (wrt_last) n_b2b++;
               if (pend) n_ovl++;
               wq.push_back(wt_data);
               wcyc.push_back(cyc);
               pend = 1'b1;
               cur = wt_data;
               clr_at = cyc + 1 + stale;
               done_at = cyc + lat;
            end
            if (cyc == clr_at) done = 1'b0;
            if (cyc == done_at) begin
               done = 1'b1;
               pend = 1'b0;
               dcyc.push_back(cyc);
               rd_data = cur[15] ? {8'($urandom), mem[cur[14:8]]} : 16'($urandom);
            end
         end
         wrt_last = wrt;
         if (vld) begin
            vq.push_back({ptch_rt, AZ});
            vcyc.push_back(cyc);
            if (vld_last) n_vld_b2b++;
         end
         vld_last = vld;
         if (init_done && !init_last) init_cyc = cyc;
         init_last = init_done;
      end
   end

   function automatic logic [31:0] exp_pair();
      return {mem[7'h23], mem[7'h22], mem[7'h2D], mem[7'h2C]};
   endfunction

   task automatic randomize_regs();
      mem[7'h22] = 8'($urandom);
      mem[7'h23] = 8'($urandom);
      mem[7'h2C] = 8'($urandom);
      mem[7'h2D] = 8'($urandom);
   endtask

   task automatic pulse_int(input int len);
      INT = 1'b1;
      repeat (len) @(negedge clk);
      INT = 1'b0;
   endtask

   task automatic test_reset();
      int c0;
      logic ok;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      if ({wrt, wt_data, ptch_rt, AZ, vld, init_done} !== 51'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got wrt=%b wt=%h p=%h az=%h vld=%b id=%b want all 0",
                  wrt, wt_data, ptch_rt, AZ, vld, init_done);
      end
      n_vec++;
      rst = 1'b0;
      c0 = cyc;
      ok = 1'b1;
      for (int i = 0; i < 50 && wq.size() == 0; i++) begin
         if ({wrt, wt_data, ptch_rt, AZ, vld, init_done} !== 51'h0) ok = 1'b0;
         @(negedge clk);
      end
      if (ok !== 1'b1) begin
         n_err++; $display("FAIL rst_wait_quiet: got %b want 1", ok);
      end
      n_vec++;
      if (wq.size() < 1) begin
         n_err++; $display("FAIL first_wrt_timeout: got %0d writes want 1", wq.size());
      end else begin
         if (wcyc[0] !== c0 + 8) begin
            n_err++; $display("FAIL first_wrt_time: got %0d want %0d", wcyc[0] - c0, 8);
         end
         n_vec++;
         if (wq[0] !== 16'h0D02) begin
            n_err++; $display("FAIL first_wrt_data: got %h want 0d02", wq[0]);
         end
      end
      n_vec++;
   endtask

   task automatic test_config();
      repeat (3) @(negedge clk);
      pulse_int(4);   // edge before init_done must be dropped
      for (int i = 0; i < 400 && !init_done; i++) @(negedge clk);
      if (init_done !== 1'b1 || wq.size() < 4 || dcyc.size() < 4) begin
         n_err++;
         $display("FAIL config_timeout: got init_done=%b writes=%0d want 1 and 4",
                  init_done, wq.size());
         n_vec++;
         return;
      end
      n_vec++;
      for (int i = 1; i < 4; i++) begin
         if (wq[i] !== cfg_cmds[i]) begin
            n_err++; $display("FAIL cfg_cmd%0d: got %h want %h", i, wq[i], cfg_cmds[i]);
         end
         n_vec++;
      end
      if (init_cyc !== dcyc[3] + 1) begin
         n_err++; $display("FAIL init_done_time: got %0d want %0d", init_cyc, dcyc[3] + 1);
      end
      n_vec++;
      repeat (60) @(negedge clk);
      if (wq.size() !== 4 || vq.size() !== 0) begin
         n_err++;
         $display("FAIL cfg_quiet: got writes=%0d vld=%0d want 4 and 0", wq.size(), vq.size());
      end
      n_vec++;
   endtask

   task automatic test_read_burst();
      int base, vb, m;
      mem[7'h22] = 8'h34; mem[7'h23] = 8'h12; mem[7'h2C] = 8'h78; mem[7'h2D] = 8'h56;
      for (int r = 0; r < 4; r++) begin
         if (r > 0) begin
            randomize_regs();
            lat = $urandom_range(3, 40);
         end
         base = wq.size(); vb = vq.size(); m = cyc;
         pulse_int(5);
         for (int i = 0; i < 600 && vq.size() == vb; i++) @(negedge clk);
         if (vq.size() !== vb + 1 || wq.size() !== base + 4) begin
            n_err++;
            $display("FAIL burst%0d_count: got vld=%0d wrt=%0d want 1 and 4",
                     r, vq.size() - vb, wq.size() - base);
            n_vec++;
            continue;
         end
         n_vec++;
         for (int i = 0; i < 4; i++) begin
            if (wq[base + i] !== rd_cmds[i]) begin
               n_err++;
               $display("FAIL burst%0d_cmd%0d: got %h want %h", r, i, wq[base + i], rd_cmds[i]);
            end
            n_vec++;
         end
         if (r == 0 && vq[vb] !== 32'h1234_5678) begin
            n_err++; $display("FAIL burst_fixed_data: got %h want 12345678", vq[vb]);
         end
         if (r != 0 && vq[vb] !== exp_pair()) begin
            n_err++; $display("FAIL burst%0d_data: got %h want %h", r, vq[vb], exp_pair());
         end
         n_vec++;
         if (wcyc[base] !== m + 4) begin
            n_err++; $display("FAIL int_latency: got %0d want %0d", wcyc[base] - m, 4);
         end
         n_vec++;
         if (vcyc[vb] !== dcyc[dcyc.size() - 1] + 2) begin
            n_err++;
            $display("FAIL vld_time: got %0d want %0d", vcyc[vb], dcyc[dcyc.size() - 1] + 2);
         end
         n_vec++;
         repeat (5) @(negedge clk);
      end
      if (n_b2b !== 0 || n_ovl !== 0 || n_vld_b2b !== 0) begin
         n_err++;
         $display("FAIL pulse_rules: got b2b=%0d overlap=%0d vld_b2b=%0d want 0 0 0",
                  n_b2b, n_ovl, n_vld_b2b);
      end
      n_vec++;
   endtask

   task automatic test_stale_done();
      int base, vb, db;
      randomize_regs();
      lat = 40; stale = 15;
      base = wq.size(); vb = vq.size(); db = dcyc.size();
      pulse_int(3);
      for (int i = 0; i < 600 && vq.size() == vb; i++) @(negedge clk);
      stale = 0;
      if (vq.size() !== vb + 1 || wq.size() !== base + 4) begin
         n_err++;
         $display("FAIL stale_count: got vld=%0d wrt=%0d want 1 and 4",
                  vq.size() - vb, wq.size() - base);
         n_vec++;
         return;
      end
      n_vec++;
      for (int i = 1; i < 4; i++) begin
         if (wcyc[base + i] !== dcyc[db + i - 1] + 1) begin
            n_err++;
            $display("FAIL stale_wrt%0d_time: got %0d want %0d",
                     i, wcyc[base + i], dcyc[db + i - 1] + 1);
         end
         n_vec++;
      end
      if (vq[vb] !== exp_pair()) begin
         n_err++; $display("FAIL stale_data: got %h want %h", vq[vb], exp_pair());
      end
      n_vec++;
   endtask

   task automatic test_back_to_back();
      int base, vb;
      randomize_regs();
      lat = 20;
      base = wq.size(); vb = vq.size();
      pulse_int(3);
      for (int i = 0; i < 300 && wq.size() < base + 2; i++) @(negedge clk);
      @(negedge clk);
      pulse_int(3);
      for (int i = 0; i < 1000 && vq.size() < vb + 2; i++) @(negedge clk);
      repeat (80) @(negedge clk);
      if (wq.size() !== base + 8 || vq.size() !== vb + 2) begin
         n_err++;
         $display("FAIL b2b_count: got wrt=%0d vld=%0d want 8 and 2",
                  wq.size() - base, vq.size() - vb);
         n_vec++;
         return;
      end
      n_vec++;
      for (int i = 0; i < 8; i++) begin
         if (wq[base + i] !== rd_cmds[i % 4]) begin
            n_err++;
            $display("FAIL b2b_cmd%0d: got %h want %h", i, wq[base + i], rd_cmds[i % 4]);
         end
         n_vec++;
      end
      for (int k = 0; k < 2; k++) begin
         if (vq[vb + k] !== exp_pair()) begin
            n_err++; $display("FAIL b2b_data%0d: got %h want %h", k, vq[vb + k], exp_pair());
         end
         n_vec++;
      end
   endtask

   task automatic test_reset_mid_burst();
      int base, vb, c0;
      randomize_regs();
      lat = 30;
      base = wq.size();
      pulse_int(3);
      for (int i = 0; i < 300 && wq.size() < base + 3; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      if ({wrt, wt_data, ptch_rt, AZ, vld, init_done} !== 51'h0) begin
         n_err++;
         $display("FAIL midrst_outputs: got wrt=%b wt=%h p=%h az=%h vld=%b id=%b want all 0",
                  wrt, wt_data, ptch_rt, AZ, vld, init_done);
      end
      n_vec++;
      rst = 1'b0;
      c0 = cyc;
      lat = 40;
      for (int i = 0; i < 600 && !init_done; i++) @(negedge clk);
      if (init_done !== 1'b1 || wq.size() !== base + 7) begin
         n_err++;
         $display("FAIL midrst_restart: got init_done=%b wrt=%0d want 1 and 7",
                  init_done, wq.size() - base);
         n_vec++;
         return;
      end
      n_vec++;
      if (wcyc[base + 3] !== c0 + 8) begin
         n_err++; $display("FAIL midrst_wait: got %0d want %0d", wcyc[base + 3] - c0, 8);
      end
      n_vec++;
      for (int i = 0; i < 4; i++) begin
         if (wq[base + 3 + i] !== cfg_cmds[i]) begin
            n_err++;
            $display("FAIL midrst_cfg%0d: got %h want %h", i, wq[base + 3 + i], cfg_cmds[i]);
         end
         n_vec++;
      end
      vb = vq.size();
      randomize_regs();
      pulse_int(3);
      for (int i = 0; i < 600 && vq.size() == vb; i++) @(negedge clk);
      if (vq.size() !== vb + 1) begin
         n_err++; $display("FAIL midrst_burst: got vld=%0d want 1", vq.size() - vb);
      end else if (vq[vb] !== exp_pair()) begin
         n_err++; $display("FAIL midrst_data: got %h want %h", vq[vb], exp_pair());
      end
      n_vec++;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      test_reset();
      test_config();
      test_read_burst();
      test_stale_done();
      test_back_to_back();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
